uart_tx_arbiter: RTL

//   Shares one uart_tx serialiser between N_REQ byte-stream requesters.

---
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_arbiter                                                          |
// | Shares one uart_tx serialiser between N_REQ byte-stream requesters using |
// | round-robin arbitration at packet granularity.                          |
// | Optional: define UART_ARB_TIMEOUT_EN to revoke idle grants.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               send,
  output logic [7:0]         data,
  input  logic               uart_busy,
  output logic               busy
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  generate
    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_cfg
      $error("uart_tx_arbiter: parameter out of range");
    end
  endgenerate

  state_t           r_state, w_state_nxt;
  logic [IW-1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [IW-1:0]    r_gidx, w_gidx_nxt;
  logic [IW-1:0]    w_win, w_cand;
  logic             w_found;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic             r_send, w_send_nxt;
  logic [7:0]       r_data, w_data_nxt;
  logic             r_last_q, w_last_q_nxt;
  logic             r_busy;
`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0]      r_to_cnt, w_to_cnt_nxt;
`endif

  // Search starts just after the last completed owner and wraps around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IW'((32'(r_rr_ptr) + 32'(k)) % 32'(N_REQ));
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_gidx_nxt   = r_gidx;
    w_grant_nxt  = r_grant;
    w_send_nxt   = 1'b0;
    w_data_nxt   = r_data;
    w_last_q_nxt = r_last_q;
`ifdef UART_ARB_TIMEOUT_EN
    w_to_cnt_nxt = r_to_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (|req_valid && !uart_busy) begin
          w_grant_nxt        = '0;
          w_grant_nxt[w_win] = 1'b1;
          w_gidx_nxt         = w_win;
          w_state_nxt        = S_LOAD;
`ifdef UART_ARB_TIMEOUT_EN
          w_to_cnt_nxt       = '0;
`endif
        end
      end
      S_LOAD: begin
        if (req_valid[r_gidx]) begin
          w_data_nxt   = req_data[{r_gidx, 3'b000} +: 8];
          w_last_q_nxt = req_last[r_gidx];
          w_send_nxt   = 1'b1;
          w_state_nxt  = S_START;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (r_to_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
          // Stalled owner forfeits its turn; nothing is sent.
          w_rr_ptr_nxt = r_gidx;
          w_grant_nxt  = '0;
          w_state_nxt  = S_IDLE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 16'd1;
        end
`endif
      end
      S_START: begin
        if (uart_busy) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!uart_busy) begin
          if (r_last_q) begin
            w_rr_ptr_nxt = r_gidx;
            w_grant_nxt  = '0;
            w_state_nxt  = S_IDLE;
          end else begin
            w_state_nxt  = S_LOAD;
`ifdef UART_ARB_TIMEOUT_EN
            w_to_cnt_nxt = '0;
`endif
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= IW'(N_REQ - 1);
      r_gidx   <= '0;
      r_grant  <= '0;
      r_send   <= 1'b0;
      r_data   <= 8'h00;
      r_last_q <= 1'b0;
      r_busy   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      r_to_cnt <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_gidx   <= w_gidx_nxt;
      r_grant  <= w_grant_nxt;
      r_send   <= w_send_nxt;
      r_data   <= w_data_nxt;
      r_last_q <= w_last_q_nxt;
      r_busy   <= |w_grant_nxt;
`ifdef UART_ARB_TIMEOUT_EN
      r_to_cnt <= w_to_cnt_nxt;
`endif
    end
  end

  assign req_ready = r_grant & {N_REQ{r_state == S_LOAD}};
  assign grant     = r_grant;
  assign send      = r_send;
  assign data      = r_data;
  assign busy      = r_busy;

endmodule
`default_nettype wire
